uart_rx_deframer: RTL and testbench

Parametrised UART receive deserialiser: samples the serial line on the oversampling baud clock, validates start, data, parity and stop bits, and presents a decoded data word with error status through a one-entry valid/ack holding register. It sits between the baud-rate sampling unit and the receive buffer, replacing the fixed 11-bit shift-and-deframe path with a single configurable block.

---
 rtl/uart_rx_deframer.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: a 2-flop synchroniser, a start/data/parity/stop FSM and a one-entry valid/ack holding register.
// Defining UART_RX_MAJORITY_VOTE_EN makes each bit a 2-of-3 vote around its nominal sample tick.
module uart_rx_deframer #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 data_tx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 active_flag
);

  // state  | meaning
  // IDLE   | line idle, waiting for s = 0
  // START  | timing to the start-bit centre, rejecting false starts
  // DATA   | sampling DATA_BITS data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling STOP_BITS stop bits
  // DONE   | frame complete, holding register update
  // BREAK  | last stop bit was low, waiting for the line to go high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAK} state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_M1 = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_M1 = BW'(STOP_BITS - 1);

  state_t state, state_nxt;

  logic sync1, s, bit_val;
  logic [TW-1:0] tick_cnt, tick_ld_val;
  logic [BW-1:0] bit_cnt, bit_ld_val;
  logic tick_tc, tick_ld, bit_ld, bit_dec;
  logic shift_en, par_en, stop_en, frame_clr, complete;
  logic [DATA_BITS-1:0] shreg;
  logic par_bad, frm_bad, last_stop, par_mismatch;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= data_tx;
      s     <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // sync1 already holds the value s takes on the next edge, so the +1 sample
  // is available at the nominal tick without moving the decision point.
  logic s_prev;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) s_prev <= 1'b1;
    else     s_prev <= s;
  end

  assign bit_val = (s_prev & s) | (s_prev & sync1) | (s & sync1);
`else
  assign bit_val = s;
`endif

  assign tick_tc     = (tick_cnt == '0);
  assign active_flag = (state != IDLE);

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tick_ld     = 1'b0;
    tick_ld_val = FULL_M1;
    bit_ld      = 1'b0;
    bit_ld_val  = DATA_M1;
    bit_dec     = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    frame_clr   = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (!s) begin
          state_nxt   = START;
          tick_ld     = 1'b1;
          tick_ld_val = HALF_M1;
        end
      end
      START: begin
        if (tick_tc) begin
          if (bit_val) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = DATA;
            tick_ld    = 1'b1;
            bit_ld     = 1'b1;
            bit_ld_val = DATA_M1;
            frame_clr  = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_tc) begin
          shift_en = 1'b1;
          tick_ld  = 1'b1;
          if (bit_cnt == '0) begin
            state_nxt  = (PARITY_MODE != 0) ? PARITY : STOP;
            bit_ld     = 1'b1;
            bit_ld_val = STOP_M1;
          end else begin
            bit_dec = 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick_tc) begin
          par_en     = 1'b1;
          tick_ld    = 1'b1;
          state_nxt  = STOP;
          bit_ld     = 1'b1;
          bit_ld_val = STOP_M1;
        end
      end
      STOP: begin
        if (tick_tc) begin
          stop_en = 1'b1;
          tick_ld = 1'b1;
          if (bit_cnt == '0) state_nxt = DONE;
          else               bit_dec   = 1'b1;
        end
      end
      DONE: begin
        complete  = 1'b1;
        state_nxt = last_stop ? IDLE : BREAK;
      end
      BREAK: begin
        if (s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick_ld)      tick_cnt <= tick_ld_val;
      else if (!tick_tc) tick_cnt <= tick_cnt - TW'(1);
      if (bit_ld)       bit_cnt <= bit_ld_val;
      else if (bit_dec) bit_cnt <= bit_cnt - BW'(1);
    end
  end

  always_comb begin
    par_mismatch = 1'b0;
    if (PARITY_MODE == 1)      par_mismatch = ^{shreg, bit_val};
    else if (PARITY_MODE == 2) par_mismatch = ~(^{shreg, bit_val});
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      par_bad   <= 1'b0;
      frm_bad   <= 1'b0;
      last_stop <= 1'b1;
    end else begin
      if (frame_clr) begin
        par_bad <= 1'b0;
        frm_bad <= 1'b0;
      end
      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (par_en)   par_bad <= par_mismatch;
      if (stop_en) begin
        last_stop <= bit_val;
        if (!bit_val) frm_bad <= 1'b1;
      end
    end
  end

  // An ack on the completion edge frees the slot, so the new word loads without overrun.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (complete && (!rx_valid || rx_ack)) begin
      rx_data     <= shreg;
      parity_err  <= par_bad;
      frame_err   <= frm_bad;
      rx_valid    <= 1'b1;
      overrun_err <= 1'b0;
    end else if (complete) begin
      overrun_err <= 1'b1;
    end else if (rx_ack && rx_valid) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: four differently parametrised instances driven with serial frames
// built from the frame format, checked against a timing/parity model computed in the bench.
module tb_uart_rx_deframer;
  logic baud_clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] data_tx = 4'hF;
  logic [3:0] rx_ack = 4'h0;
  wire  [3:0] vld, per, frm, ovr, act;
  wire  [7:0] d0, d1, d2;
  wire  [8:0] d3;
  int tests = 0;
  int fails = 0;
  int db_c[4] = '{8, 8, 8, 9};
  int pm_c[4] = '{0, 1, 2, 2};
  int sb_c[4] = '{1, 1, 1, 2};
  int os_c[4] = '{16, 16, 16, 10};

  always #5 baud_clk = ~baud_clk;

  uart_rx_deframer #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .baud_clk(baud_clk), .rst(rst), .data_tx(data_tx[0]), .rx_ack(rx_ack[0]), .rx_data(d0),
    .rx_valid(vld[0]), .parity_err(per[0]), .frame_err(frm[0]), .overrun_err(ovr[0]), .active_flag(act[0]));
  uart_rx_deframer #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .baud_clk(baud_clk), .rst(rst), .data_tx(data_tx[1]), .rx_ack(rx_ack[1]), .rx_data(d1),
    .rx_valid(vld[1]), .parity_err(per[1]), .frame_err(frm[1]), .overrun_err(ovr[1]), .active_flag(act[1]));
  uart_rx_deframer #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16)) u2 (
    .baud_clk(baud_clk), .rst(rst), .data_tx(data_tx[2]), .rx_ack(rx_ack[2]), .rx_data(d2),
    .rx_valid(vld[2]), .parity_err(per[2]), .frame_err(frm[2]), .overrun_err(ovr[2]), .active_flag(act[2]));
  uart_rx_deframer #(.DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(10)) u3 (
    .baud_clk(baud_clk), .rst(rst), .data_tx(data_tx[3]), .rx_ack(rx_ack[3]), .rx_data(d3),
    .rx_valid(vld[3]), .parity_err(per[3]), .frame_err(frm[3]), .overrun_err(ovr[3]), .active_flag(act[3]));

  function automatic logic [8:0] get_dat(input int i);
    case (i)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {1'b0, d2};
      default: return d3;
    endcase
  endfunction

  // Cycles from driving the start bit to rx_valid visible: 2 sync, detect, half bit, remaining bits, +1 update.
  function automatic int exp_lat(input int i);
    return 4 + os_c[i] / 2 + (db_c[i] + ((pm_c[i] != 0) ? 1 : 0) + sb_c[i]) * os_c[i];
  endfunction

  function automatic int good_par(input int i, input int d);
    if (pm_c[i] == 1) return $countones(d) % 2;
    if (pm_c[i] == 2) return 1 - ($countones(d) % 2);
    return 0;
  endfunction

  function automatic int exp_perr(input int i, input int d, input int p);
    int ones = $countones(d) + p;
    if (pm_c[i] == 1) return ones % 2;
    if (pm_c[i] == 2) return 1 - (ones % 2);
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic ack(input int i);
    rx_ack[i] = 1'b1;
    @(negedge baud_clk);
    rx_ack[i] = 1'b0;
  endtask

  // Drives one frame; reports the cycle count at which rx_valid rose and active_flag fell (-1 if never).
  task automatic send_frame(input int i, input int d, input bit par_flip, input bit [1:0] stop_hi,
                            input bit spike, input int ack_at, input int abort_at,
                            output int rise_n, output int fall_n);
    bit bits[$];
    bit pv, pa, b;
    int n;
    bits.push_back(1'b0);
    for (int k = 0; k < db_c[i]; k++) bits.push_back(d[k]);
    if (pm_c[i] != 0) bits.push_back(1'(good_par(i, d)) ^ par_flip);
    for (int k = 0; k < sb_c[i]; k++) bits.push_back(stop_hi[k]);
    n = 0; rise_n = -1; fall_n = -1;
    pv = vld[i]; pa = act[i];
    foreach (bits[j]) begin
      for (int c = 0; c < os_c[i]; c++) begin
        b = bits[j];
        data_tx[i] = (spike && c == os_c[i] / 2) ? ~b : b;
        @(negedge baud_clk);
        n++;
        if (vld[i] && !pv && rise_n < 0) rise_n = n;
        if (!act[i] && pa && fall_n < 0) fall_n = n;
        pv = vld[i]; pa = act[i];
        rx_ack[i] = (ack_at > 0 && n == ack_at - 1);
        if (abort_at > 0 && n >= abort_at) return;
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({vld[i], per[i], frm[i], ovr[i], act[i]} !== 5'b0) begin
        fails++; $display("FAIL reset_flags[%0d]: got %b want 00000", i, {vld[i], per[i], frm[i], ovr[i], act[i]});
      end
      tests++;
      if (get_dat(i) !== 9'd0) begin
        fails++; $display("FAIL reset_data[%0d]: got %h want 0", i, get_dat(i));
      end
    end
    rst = 1'b0;
    idle(5);
    tests++;
    if ((vld | act) !== 4'b0) begin
      fails++; $display("FAIL post_reset_idle: got %b want 0000", vld | act);
    end
  endtask

  task automatic test_basic;
    int r, f;
    send_frame(0, 'hA5, 1'b0, 2'b11, 1'b0, 0, 0, r, f);
    data_tx[0] = 1'b1;
    tests++;
    if (r !== exp_lat(0)) begin fails++; $display("FAIL basic_latency: got %0d want %0d", r, exp_lat(0)); end
    tests++;
    if (f !== exp_lat(0)) begin fails++; $display("FAIL basic_active_fall: got %0d want %0d", f, exp_lat(0)); end
    tests++;
    if ({get_dat(0), per[0], frm[0], ovr[0]} !== {9'h0A5, 3'b000}) begin
      fails++; $display("FAIL basic_word: got %h p%b f%b o%b want a5 p0 f0 o0", get_dat(0), per[0], frm[0], ovr[0]);
    end
    ack(0);
    tests++;
    if (vld[0] !== 1'b0) begin fails++; $display("FAIL basic_ack: got %b want 0", vld[0]); end
    idle(4);
  endtask

  task automatic test_random;
    int i, d, r, f, p, efrm;
    bit flip;
    bit [1:0] sh;
    for (int it = 0; it < 12; it++) begin
      i = it % 4;
      d = int'($urandom_range(0, (1 << db_c[i]) - 1));
      flip = (pm_c[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sh = (sb_c[i] == 2) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b11;
      p = good_par(i, d) ^ int'(flip);
      efrm = 0;
      for (int k = 0; k < sb_c[i]; k++) if (!sh[k]) efrm = 1;
      send_frame(i, d, flip, sh, 1'b0, 0, 0, r, f);
      data_tx[i] = 1'b1;
      tests++;
      if (r !== exp_lat(i) || f !== exp_lat(i)) begin
        fails++; $display("FAIL rand_timing[%0d]: got rise %0d fall %0d want %0d", it, r, f, exp_lat(i));
      end
      tests++;
      if (get_dat(i) !== 9'(d)) begin fails++; $display("FAIL rand_data[%0d]: got %h want %h", it, get_dat(i), d); end
      tests++;
      if ({per[i], frm[i]} !== {1'(exp_perr(i, d, p)), 1'(efrm)}) begin
        fails++; $display("FAIL rand_flags[%0d]: got p%b f%b want p%0d f%0d", it, per[i], frm[i], exp_perr(i, d, p), efrm);
      end
      ack(i);
      tests++;
      if (vld[i] !== 1'b0) begin fails++; $display("FAIL rand_ack[%0d]: got %b want 0", it, vld[i]); end
      idle(os_c[i]);
    end
  endtask

  task automatic test_parity;
    int idx[4] = '{1, 1, 2, 2};
    bit pb[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int r, f, i;
    for (int c = 0; c < 4; c++) begin
      i = idx[c];
      send_frame(i, 'h07, pb[c] ^ 1'(good_par(i, 'h07)), 2'b11, 1'b0, 0, 0, r, f);
      data_tx[i] = 1'b1;
      tests++;
      if ({vld[i], per[i], get_dat(i)} !== {1'b1, exp[c], 9'h007}) begin
        fails++; $display("FAIL parity_case%0d: got v%b p%b d%h want v1 p%b d07", c, vld[i], per[i], get_dat(i), exp[c]);
      end
      ack(i);
      idle(4);
    end
  endtask

  task automatic test_glitch;
    int cnt = 0;
    bit saw_vld = 1'b0;
    data_tx[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge baud_clk);
      if (c == 5) data_tx[0] = 1'b1;
      cnt += int'(act[0]);
      if (vld[0]) saw_vld = 1'b1;
    end
    tests++;
    if (cnt !== 8) begin fails++; $display("FAIL glitch_active_cycles: got %0d want 8", cnt); end
    tests++;
    if (saw_vld !== 1'b0 || act[0] !== 1'b0) begin
      fails++; $display("FAIL glitch_reject: got v%b a%b want v0 a0", saw_vld, act[0]);
    end
  endtask

  task automatic test_break;
    int r, f, d, d2;
    d = int'($urandom_range(0, 511));
    send_frame(3, d, 1'b0, 2'b01, 1'b0, 0, 0, r, f);
    idle(3);
    tests++;
    if ({r == exp_lat(3), frm[3], act[3], get_dat(3)} !== {1'b1, 1'b1, 1'b1, 9'(d)}) begin
      fails++; $display("FAIL break_frame: got rise %0d f%b a%b d%h want %0d f1 a1 d%h", r, frm[3], act[3], get_dat(3), exp_lat(3), d);
    end
    ack(3);
    idle(5 * os_c[3]);
    tests++;
    if ({vld[3], act[3]} !== 2'b01) begin fails++; $display("FAIL break_hold: got v%b a%b want v0 a1", vld[3], act[3]); end
    data_tx[3] = 1'b1;
    idle(4);
    tests++;
    if (act[3] !== 1'b0) begin fails++; $display("FAIL break_exit: got %b want 0", act[3]); end
    d2 = int'($urandom_range(0, 511));
    send_frame(3, d2, 1'b0, 2'b11, 1'b0, 0, 0, r, f);
    data_tx[3] = 1'b1;
    tests++;
    if ({r == exp_lat(3), frm[3], per[3], get_dat(3)} !== {1'b1, 1'b0, 1'b0, 9'(d2)}) begin
      fails++; $display("FAIL break_next: got rise %0d f%b p%b d%h want %0d f0 p0 d%h", r, frm[3], per[3], get_dat(3), exp_lat(3), d2);
    end
    ack(3);
    idle(4);
  endtask

  task automatic test_back_to_back;
    int r1, r2, f;
    send_frame(0, 'h11, 1'b0, 2'b11, 1'b0, 0, 0, r1, f);
    send_frame(0, 'h22, 1'b0, 2'b11, 1'b0, 0, 0, r2, f);
    data_tx[0] = 1'b1;
    tests++;
    if ({r1 == exp_lat(0), vld[0], ovr[0], get_dat(0)} !== {3'b111, 9'h011}) begin
      fails++; $display("FAIL overrun: got rise %0d v%b o%b d%h want v1 o1 d11", r1, vld[0], ovr[0], get_dat(0));
    end
    ack(0);
    tests++;
    if ({vld[0], ovr[0]} !== 2'b00) begin fails++; $display("FAIL overrun_ack: got v%b o%b want 00", vld[0], ovr[0]); end
    idle(4);
    send_frame(0, 'h11, 1'b0, 2'b11, 1'b0, 0, 0, r1, f);
    send_frame(0, 'h22, 1'b0, 2'b11, 1'b0, exp_lat(0), 0, r2, f);
    data_tx[0] = 1'b1;
    rx_ack[0] = 1'b0;
    tests++;
    if ({vld[0], ovr[0], get_dat(0)} !== {2'b10, 9'h022}) begin
      fails++; $display("FAIL same_edge_ack: got v%b o%b d%h want v1 o0 d22", vld[0], ovr[0], get_dat(0));
    end
    ack(0);
    idle(4);
  endtask

  task automatic test_reset_mid;
    int r, f;
    send_frame(0, 'h5A, 1'b0, 2'b11, 1'b0, 0, 0, r, f);
    send_frame(0, 'h66, 1'b0, 2'b11, 1'b0, 0, 0, r, f);
    send_frame(0, 'hFF, 1'b0, 2'b11, 1'b0, 0, 5 * os_c[0] + os_c[0] / 2, r, f);
    tests++;
    if ({vld[0], ovr[0], act[0]} !== 3'b111) begin fails++; $display("FAIL pre_reset: got %b want 111", {vld[0], ovr[0], act[0]}); end
    rst = 1'b1;
    @(negedge baud_clk);
    tests++;
    if ({vld[0], per[0], frm[0], ovr[0], act[0], get_dat(0)} !== 14'b0) begin
      fails++; $display("FAIL mid_reset: got v%b p%b f%b o%b a%b d%h want all 0", vld[0], per[0], frm[0], ovr[0], act[0], get_dat(0));
    end
    idle(2);
    data_tx[0] = 1'b1;
    rst = 1'b0;
    idle(5);
    send_frame(0, 'h3C, 1'b0, 2'b11, 1'b0, 0, 0, r, f);
    data_tx[0] = 1'b1;
    tests++;
    if ({r == exp_lat(0), per[0], frm[0], get_dat(0)} !== {3'b100, 9'h03C}) begin
      fails++; $display("FAIL after_reset: got rise %0d p%b f%b d%h want %0d p0 f0 d3c", r, per[0], frm[0], get_dat(0), exp_lat(0));
    end
    ack(0);
    idle(4);
  endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
  task automatic test_majority;
    int r, f;
    send_frame(0, 'h3C, 1'b0, 2'b11, 1'b1, 0, 0, r, f);
    data_tx[0] = 1'b1;
    tests++;
    if ({r == exp_lat(0), frm[0], get_dat(0)} !== {2'b10, 9'h03C}) begin
      fails++; $display("FAIL majority_spike: got rise %0d f%b d%h want %0d f0 d3c", r, frm[0], get_dat(0), exp_lat(0));
    end
    ack(0);
    idle(4);
  endtask
`endif

  initial begin
    idle(3);
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_random;
    test_break;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_majority;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
